// File: rtl/fifos_arbitro.sv
// Four per-lane FIFOs drained round-robin onto one registered, lane-tagged output stream.
// Optional sticky per-lane overflow flags are built when FIFO_ERR_EN is defined.
//
// state  | meaning
// IDLE   | all FIFOs empty, no pushes arriving, no output in flight; idle_out=1
// ACTIVE | words buffered, arriving or being emitted
module fifos_arbitro #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AF_TH  = 3,
    parameter int AE_TH  = 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_0_cond,
    input  logic [DATA_W-1:0] data_1_cond,
    input  logic [DATA_W-1:0] data_2_cond,
    input  logic [DATA_W-1:0] data_3_cond,
    input  logic              valid_0_cond,
    input  logic              valid_1_cond,
    input  logic              valid_2_cond,
    input  logic              valid_3_cond,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        dest_out,
    output logic              valid_out,
    output logic [3:0]        almost_full,
    output logic [3:0]        almost_empty,
    output logic [3:0]        empty,
    output logic              pause,
    output logic              idle_out,
    output logic [3:0]        fifo_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem    [4][DEPTH];
    logic [PW-1:0]     wr_ptr [4];
    logic [PW-1:0]     rd_ptr [4];
    logic [CW-1:0]     count  [4];
    logic [DATA_W-1:0] din    [4];
    logic [3:0]        push_req;
    logic [3:0]        push;
    logic [3:0]        pop;
    logic [1:0]        rr_ptr;
    logic [1:0]        grant;
    logic              grant_vld;

    assign din[0]   = data_0_cond;
    assign din[1]   = data_1_cond;
    assign din[2]   = data_2_cond;
    assign din[3]   = data_3_cond;
    assign push_req = {valid_3_cond, valid_2_cond, valid_1_cond, valid_0_cond};

    // Descending scan so the lane closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant     = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (pop_ready && !empty[rr_ptr + 2'(k)]) begin
                grant_vld = 1'b1;
                grant     = rr_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        pop = 4'b0000;
        if (grant_vld) pop = 4'b0001 << grant;
    end

    // A full FIFO still accepts a push when it is popped in the same cycle.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            push[l] = push_req[l] && ((count[l] != CW'(DEPTH)) || pop[l]);
        end
    end

    always_comb begin
        for (int l = 0; l < 4; l++) begin
            empty[l]        = (count[l] == '0);
            almost_full[l]  = (count[l] >= CW'(AF_TH));
            almost_empty[l] = (count[l] <= CW'(AE_TH));
        end
    end

    assign pause = |almost_full;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int l = 0; l < 4; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
                count[l]  <= '0;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (push[l]) wr_ptr[l] <= wr_ptr[l] + 1'b1;
                if (pop[l])  rd_ptr[l] <= rd_ptr[l] + 1'b1;
                count[l] <= count[l] + CW'(push[l]) - CW'(pop[l]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (push[l]) mem[l][wr_ptr[l]] <= din[l];
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            dest_out  <= '0;
            valid_out <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            valid_out <= grant_vld;
            if (grant_vld) begin
                data_out <= mem[grant][rd_ptr[grant]];
                dest_out <= grant;
                rr_ptr   <= grant + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!(&empty) || (|push_req)) state_d = ACTIVE;
            ACTIVE:  if ((&empty) && !(|push_req) && !grant_vld) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idle_out = (state_q == IDLE);
    end

`ifdef FIFO_ERR_EN
    logic [3:0] err_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) err_q <= 4'b0000;
        else          err_q <= err_q | (push_req & ~push);
    end

    assign fifo_error = err_q;
`else
    assign fifo_error = 4'b0000;
`endif

endmodule
